// File: rtl/silife_uart_bridge_if.sv
// Byte-stream and grid-core signals between the UART command bridge and its surroundings.
// The bridge uses the master modport; the UART/core side uses slave.
interface silife_uart_bridge_if #(
  parameter int ROW_W = 5,
  parameter int COLS  = 8
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [ROW_W-1:0] grid_row;
  logic [COLS-1:0]  grid_wdata;
  logic             grid_wr_en;
  logic [COLS-1:0]  grid_rdata;
  logic             grid_step;
  logic             disp_en;
  logic             busy;
  logic             rx_drop;

  modport master (
    input  rx_data, rx_valid, tx_ready, grid_rdata,
    output tx_data, tx_valid, grid_row, grid_wdata, grid_wr_en, grid_step,
           disp_en, busy, rx_drop
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, grid_rdata,
    input  tx_data, tx_valid, grid_row, grid_wdata, grid_wr_en, grid_step,
           disp_en, busy, rx_drop
  );
endinterface

// File: rtl/silife_uart_bridge.sv
// UART command interpreter for the Game-of-Life core: digits set a repeat count,
// s/S/R step the core, r/R dump the grid as ASCII rows, w/W + '.'/'#' load cells.
//
// state   | meaning
// IDLE    | waiting for a command byte
// ECHO    | loading the echo/response byte into TX
// STEP    | issuing grid_step pulses, one low cycle between pulses
// DUMP_RD | row select settling, then latch grid_rdata
// DUMP_CH | sending one '#'/'.' per column
// DUMP_CR | sending carriage return
// DUMP_LF | sending line feed, then next row or finish
module silife_uart_bridge #(
  parameter int ROWS  = 32,
  parameter int ROW_W = 5,
  parameter int COLS  = 8
) (
  input logic clk,
  input logic rst,
  silife_uart_bridge_if.master bus
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [2:0] {IDLE, ECHO, STEP, DUMP_RD, DUMP_CH, DUMP_CR, DUMP_LF} state_t;

  state_t           state_q, state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COLS-1:0]  wdata_q, wdata_d;
  logic             wr_en_q, wr_en_d;
  logic             step_q, step_d;
  logic             disp_en_q, disp_en_d;
  logic             drop_q, drop_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             wmode_q, wmode_d;
  logic [ROW_W-1:0] wrow_q, wrow_d;
  logic [CW-1:0]    col_q, col_d;
  logic [COLS-1:0]  buf_q, buf_d;
  logic [7:0]       n_q, n_d;
  logic [7:0]       echo_q, echo_d;
  logic             hdr_q, hdr_d;
  logic             dump_after_q, dump_after_d;
  logic             rdw_q, rdw_d;

  logic        tx_free, rx_ok, is_digit, is_cell;
  logic [11:0] cnt_ext;
  logic [7:0]  n_cmd;

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    row_d        = row_q;
    wdata_d      = wdata_q;
    wr_en_d      = 1'b0;
    step_d       = 1'b0;
    disp_en_d    = disp_en_q;
    drop_d       = 1'b0;
    cnt_d        = cnt_q;
    wmode_d      = wmode_q;
    wrow_d       = wrow_q;
    col_d        = col_q;
    buf_d        = buf_q;
    n_d          = n_q;
    echo_d       = echo_q;
    hdr_d        = hdr_q;
    dump_after_d = dump_after_q;
    rdw_d        = rdw_q;

    // A byte may be loaded whenever the holding register is empty or draining this cycle.
    tx_free  = !tx_valid_q || bus.tx_ready;
    rx_ok    = (state_q == IDLE) && !tx_valid_q;
    is_digit = (bus.rx_data >= "0") && (bus.rx_data <= "9");
    is_cell  = (bus.rx_data == ".") || (bus.rx_data == "#");
    cnt_ext  = 12'(cnt_q) * 12'd10 + 12'(bus.rx_data[3:0]);
    n_cmd    = (cnt_q == 8'd0) ? 8'd1 : cnt_q;

    if (tx_valid_q && bus.tx_ready) tx_valid_d = 1'b0;
    if (bus.rx_valid && !rx_ok) drop_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.rx_valid && rx_ok) begin
          echo_d  = "X";
          state_d = ECHO;
          if (is_digit) begin
            cnt_d  = (cnt_ext > 12'd255) ? 8'd255 : cnt_ext[7:0];
            echo_d = bus.rx_data;
          end else if (is_cell) begin
            if (wmode_q) begin
              buf_d[col_q] = (bus.rx_data == "#");
              echo_d       = bus.rx_data;
              if (col_q == CW'(COLS - 1)) begin
                wr_en_d = 1'b1;
                row_d   = wrow_q;
                wdata_d = buf_d;
                col_d   = '0;
                wrow_d  = wrow_q + ROW_W'(1);
                if (wrow_q == ROW_W'(ROWS - 1)) wmode_d = 1'b0;
              end else begin
                col_d = col_q + CW'(1);
              end
            end
          end else begin
            cnt_d   = 8'd0;
            wmode_d = 1'b0;
            case (bus.rx_data)
              "s", "S", "R": begin
                n_d          = n_cmd;
                dump_after_d = (bus.rx_data == "R");
                state_d      = STEP;
              end
              "r": begin
                disp_en_d = 1'b0;
                hdr_d     = 1'b1;
                state_d   = DUMP_CR;
              end
              "w", "W": begin
                wmode_d = 1'b1;
                wrow_d  = '0;
                col_d   = '0;
                echo_d  = "W";
              end
              default: ;
            endcase
          end
        end
      end
      ECHO: begin
        if (tx_free) begin
          tx_valid_d = 1'b1;
          tx_data_d  = echo_q;
          state_d    = IDLE;
        end
      end
      STEP: begin
        if (step_q) begin
          step_d = 1'b0;
        end else if (n_q != 8'd0) begin
          step_d = 1'b1;
          n_d    = n_q - 8'd1;
        end else if (dump_after_q) begin
          disp_en_d = 1'b0;
          hdr_d     = 1'b1;
          state_d   = DUMP_CR;
        end else begin
          echo_d  = "S";
          state_d = ECHO;
        end
      end
      DUMP_CR: begin
        if (tx_free) begin
          tx_valid_d = 1'b1;
          tx_data_d  = 8'h0d;
          state_d    = DUMP_LF;
        end
      end
      DUMP_LF: begin
        if (tx_free) begin
          tx_valid_d = 1'b1;
          tx_data_d  = 8'h0a;
          if (hdr_q) begin
            hdr_d   = 1'b0;
            row_d   = '0;
            state_d = DUMP_RD;
          end else if (row_q == ROW_W'(ROWS - 1)) begin
            disp_en_d = 1'b1;
            row_d     = '0;
            state_d   = IDLE;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = DUMP_RD;
          end
        end
      end
      DUMP_RD: begin
        // First cycle lets the core's registered read follow the new row select.
        if (!rdw_q) begin
          rdw_d = 1'b1;
        end else begin
          rdw_d   = 1'b0;
          buf_d   = bus.grid_rdata;
          col_d   = '0;
          state_d = DUMP_CH;
        end
      end
      DUMP_CH: begin
        if (tx_free) begin
          tx_valid_d = 1'b1;
          tx_data_d  = buf_q[col_q] ? "#" : ".";
          if (col_q == CW'(COLS - 1)) begin
            col_d   = '0;
            state_d = DUMP_CR;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      row_q        <= '0;
      wdata_q      <= '0;
      wr_en_q      <= 1'b0;
      step_q       <= 1'b0;
      disp_en_q    <= 1'b1;
      drop_q       <= 1'b0;
      cnt_q        <= 8'd0;
      wmode_q      <= 1'b0;
      wrow_q       <= '0;
      col_q        <= '0;
      buf_q        <= '0;
      n_q          <= 8'd0;
      echo_q       <= 8'h00;
      hdr_q        <= 1'b0;
      dump_after_q <= 1'b0;
      rdw_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      row_q        <= row_d;
      wdata_q      <= wdata_d;
      wr_en_q      <= wr_en_d;
      step_q       <= step_d;
      disp_en_q    <= disp_en_d;
      drop_q       <= drop_d;
      cnt_q        <= cnt_d;
      wmode_q      <= wmode_d;
      wrow_q       <= wrow_d;
      col_q        <= col_d;
      buf_q        <= buf_d;
      n_q          <= n_d;
      echo_q       <= echo_d;
      hdr_q        <= hdr_d;
      dump_after_q <= dump_after_d;
      rdw_q        <= rdw_d;
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.grid_row   = row_q;
  assign bus.grid_wdata = wdata_q;
  assign bus.grid_wr_en = wr_en_q;
  assign bus.grid_step  = step_q;
  assign bus.disp_en    = disp_en_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.rx_drop    = drop_q;
endmodule

// File: tb/tb_silife_uart_bridge.sv
// Directed bench for the UART bridge with a 4x8 grid core model and a TX monitor.
module tb_silife_uart_bridge;
  localparam int ROWS = 4, ROW_W = 2, COLS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  silife_uart_bridge_if #(.ROW_W(ROW_W), .COLS(COLS)) ifc ();
  silife_uart_bridge #(.ROWS(ROWS), .ROW_W(ROW_W), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .bus(ifc)
  );

  // Core model: registered row read, row write on strobe.
  logic [COLS-1:0] mem [ROWS];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= '0;
      ifc.grid_rdata <= '0;
    end else begin
      if (ifc.grid_wr_en) mem[ifc.grid_row] <= ifc.grid_wdata;
      ifc.grid_rdata <= mem[ifc.grid_row];
    end
  end

  typedef struct { logic [ROW_W-1:0] row; logic [COLS-1:0] data; } wr_t;
  typedef struct { logic [7:0] cmd; logic [7:0] echo; int steps; } vec_t;

  logic [7:0] txq[$];
  bit         dq[$];
  wr_t        wrq[$];
  int step_cnt = 0, adj_err = 0, both_err = 0, stab_err = 0, drop_cnt = 0;
  bit pv = 0, pr = 0, ps = 0;
  logic [7:0] pd = 8'h00;
  int ph = 0;
  bit rdy_mode = 0;
  int checks = 0, errors = 0;

  // tx_ready is updated first so the monitor sees the value the next posedge uses.
  always @(negedge clk) begin
    ph = (ph == 2) ? 0 : ph + 1;
    ifc.tx_ready = rdy_mode ? (ph == 0) : 1'b1;
    if (rst) begin
      pv = 0;
      ps = 0;
    end else begin
      if (pv && !pr && (!ifc.tx_valid || ifc.tx_data != pd)) stab_err++;
      if (ifc.tx_valid && ifc.tx_ready) begin
        txq.push_back(ifc.tx_data);
        dq.push_back(ifc.disp_en);
      end
      if (ifc.grid_step) begin
        step_cnt++;
        if (ps) adj_err++;
      end
      if (ifc.grid_step && ifc.grid_wr_en) both_err++;
      if (ifc.grid_wr_en) wrq.push_back('{ifc.grid_row, ifc.grid_wdata});
      if (ifc.rx_drop) drop_cnt++;
      pv = ifc.tx_valid;
      pr = ifc.tx_ready;
      pd = ifc.tx_data;
      ps = ifc.grid_step;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    bit done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (!ifc.busy && !ifc.tx_valid) done = 1;
    end
    if (!done) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    @(negedge clk);
    ifc.rx_data  = b;
    ifc.rx_valid = 1'b1;
    @(negedge clk);
    ifc.rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    wait_idle("send");
    pulse_rx(b);
  endtask

  task automatic clear_logs();
    txq.delete();
    dq.delete();
    wrq.delete();
    step_cnt = 0;
    drop_cnt = 0;
  endtask

  task automatic check_dump(input string nm, input int ofs, input logic [7:0] rows[ROWS]);
    logic [7:0] exp[$];
    int bad = 0, dbad = 0;
    exp.push_back(8'h0d);
    exp.push_back(8'h0a);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) exp.push_back(rows[r][c] ? "#" : ".");
      exp.push_back(8'h0d);
      exp.push_back(8'h0a);
    end
    chk({nm, "_len"}, txq.size(), ofs + exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (ofs + i >= txq.size() || txq[ofs + i] !== exp[i]) bad++;
      else if (i < exp.size() - 1 && dq[ofs + i]) dbad++;
    end
    chk({nm, "_bytes_bad"}, bad, 0);
    chk({nm, "_disp_en_high"}, dbad, 0);
  endtask

  vec_t vt[16];
  logic [7:0] pat[ROWS];

  initial begin
    vt[0]  = '{"1", "1", 0};
    vt[1]  = '{"2", "2", 0};
    vt[2]  = '{"s", "S", 12};
    vt[3]  = '{"s", "S", 1};
    vt[4]  = '{"3", "3", 0};
    vt[5]  = '{"Q", "X", 0};
    vt[6]  = '{"S", "S", 1};
    vt[7]  = '{"#", "X", 0};
    vt[8]  = '{".", "X", 0};
    vt[9]  = '{"9", "9", 0};
    vt[10] = '{"9", "9", 0};
    vt[11] = '{"9", "9", 0};
    vt[12] = '{"s", "S", 255};
    vt[13] = '{"0", "0", 0};
    vt[14] = '{"S", "S", 1};
    vt[15] = '{"Z", "X", 0};
    pat = '{8'h01, 8'h80, 8'hFF, 8'h00};

    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_tx_valid", ifc.tx_valid, 0);
    chk("rst_tx_data", ifc.tx_data, 0);
    chk("rst_grid_row", ifc.grid_row, 0);
    chk("rst_grid_wdata", ifc.grid_wdata, 0);
    chk("rst_disp_en", ifc.disp_en, 1);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_rx_drop", ifc.rx_drop, 0);
    chk("rst_strobes", step_cnt + wrq.size() + txq.size(), 0);

    foreach (vt[i]) begin
      clear_logs();
      send(vt[i].cmd);
      wait_idle("vec");
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d_nbytes", i), txq.size(), 1);
      if (txq.size() > 0) chk($sformatf("vec%0d_echo", i), txq[0], vt[i].echo);
      chk($sformatf("vec%0d_steps", i), step_cnt, vt[i].steps);
    end

    // Write mode: 4 rows of 0x55 then write mode closes.
    clear_logs();
    send("w");
    for (int k = 0; k < ROWS * COLS; k++) send((k % 2 == 0) ? "#" : ".");
    send("#");
    wait_idle("wr");
    repeat (2) @(negedge clk);
    chk("wr_nbytes", txq.size(), ROWS * COLS + 2);
    if (txq.size() == ROWS * COLS + 2) begin
      chk("wr_echo_W", txq[0], "W");
      chk("wr_echo_cell31", txq[32], ".");
      chk("wr_echo_after", txq[33], "X");
    end
    chk("wr_pulses", wrq.size(), ROWS);
    foreach (wrq[i]) begin
      chk($sformatf("wr%0d_row", i), wrq[i].row, i);
      chk($sformatf("wr%0d_data", i), wrq[i].data, 8'h55);
    end

    // Partial row is discarded by a non-cell command.
    clear_logs();
    send("w"); send("#"); send("#"); send("x"); send("#");
    wait_idle("partial");
    repeat (2) @(negedge clk);
    chk("partial_wr_pulses", wrq.size(), 0);
    chk("partial_nbytes", txq.size(), 5);
    if (txq.size() == 5) chk("partial_last_echo", txq[4], "X");

    // Load dump pattern through the UART.
    clear_logs();
    send("w");
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) send(pat[r][c] ? "#" : ".");
    wait_idle("load");
    repeat (2) @(negedge clk);
    chk("load_pulses", wrq.size(), ROWS);
    foreach (wrq[i]) chk($sformatf("load%0d_data", i), wrq[i].data, pat[i]);

    // Dump with 1-of-3 tx_ready and a dropped command mid-dump.
    clear_logs();
    rdy_mode = 1;
    send("r");
    repeat (10) @(negedge clk);
    chk("dump_disp_en_mid", ifc.disp_en, 0);
    pulse_rx("s");
    wait_idle("dump");
    repeat (3) @(negedge clk);
    check_dump("dump", 0, pat);
    chk("dump_drops", drop_cnt, 1);
    chk("dump_steps", step_cnt, 0);
    chk("dump_busy_end", ifc.busy, 0);
    chk("dump_disp_en_end", ifc.disp_en, 1);
    chk("dump_row_end", ifc.grid_row, 0);

    // 'R': step by count, then dump instead of echoing 'S'.
    clear_logs();
    send("2");
    send("R");
    wait_idle("stepdump");
    repeat (3) @(negedge clk);
    chk("R_steps", step_cnt, 2);
    if (txq.size() > 0) chk("R_first", txq[0], "2");
    check_dump("R_dump", 1, pat);
    rdy_mode = 0;

    // Reset in the middle of the column characters.
    clear_logs();
    send("r");
    for (int i = 0; i < 200 && txq.size() < 4; i++) @(negedge clk);
    chk("mid_in_dump", ifc.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx_valid", ifc.tx_valid, 0);
    chk("mid_rst_disp_en", ifc.disp_en, 1);
    chk("mid_rst_busy", ifc.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    send("S");
    wait_idle("post_rst");
    repeat (2) @(negedge clk);
    chk("post_rst_steps", step_cnt, 1);
    chk("post_rst_nbytes", txq.size(), 1);
    if (txq.size() > 0) chk("post_rst_echo", txq[0], "S");

    chk("adjacent_steps", adj_err, 0);
    chk("step_and_write", both_err, 0);
    chk("tx_stability", stab_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/silife_uart_bridge.md
Name: silife_uart_bridge

Overview:
- UART command interpreter between a byte-stream UART (rx/tx valid/ready) and a parametrised Game-of-Life grid core.
- Steps the simulation (single or N-repeat), dumps the grid as ASCII, and loads the grid cell by cell.
- Grid size (ROWS x COLS) is a parameter; step repeat count comes from decimal digits; TX uses full ready/valid backpressure.
- Sits between uart_rx/uart_tx and the silife core; owns the core's row-select, write and step strobes.

Parameters:
- ROWS, 32, number of grid rows (2..256).
- ROW_W, 5, width of the row index; must be >= clog2(ROWS).
- COLS, 8, cells per row (1..32); column c maps to data bit c.

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid; one-cycle pulse, no backpressure
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART accepts; a transfer occurs when tx_valid && tx_ready
- grid_row  out  ROW_W  row select to core
- grid_wdata  out  COLS  row write data
- grid_wr_en  out  1  one-cycle row write strobe
- grid_rdata  in  COLS  row read data; valid 1 cycle after grid_row changes
- grid_step  out  1  one-cycle generation-advance strobe
- disp_en  out  1  display engine enable; 0 while dumping
- busy  out  1  high when not in IDLE
- rx_drop  out  1  one-cycle pulse when an rx byte is discarded

Behaviour:
- Reset: tx_valid=0, tx_data=8'h00, grid_row=0, grid_wdata=0, grid_wr_en=0, grid_step=0, disp_en=1, busy=0, rx_drop=0; count=0; write mode off; state IDLE. Reset mid-operation aborts at once; no partial byte or strobe follows.
- TX rule: once tx_valid rises, tx_data and tx_valid stay stable until tx_ready is sampled high. tx_valid drops the cycle after the transfer unless the next byte is loaded in the same cycle.
- RX is accepted only in IDLE with no pending TX byte. Otherwise the byte is dropped and rx_drop pulses.
- States: IDLE, ECHO, STEP, DUMP_RD, DUMP_CH, DUMP_CR, DUMP_LF.
- Commands accepted in IDLE:
  - '0'..'9': count = min(count*10 + d, 255); echo the digit.
  - 's'/'S': enter STEP with N = (count==0 ? 1 : count); count cleared. STEP issues N grid_step pulses, each followed by at least one low cycle, then echoes 'S' and returns to IDLE.
  - 'r': dump. 'R': STEP with N as above, then dump instead of echoing 'S'.
  - 'w'/'W': write mode on, write row=0, col=0; echo 'W'.
  - '.'/'#' in write mode: set bit col of the row buffer (1 for '#'), echo the char, col++. After the COLS-th cell, grid_wr_en pulses for exactly one cycle with grid_row = write row and grid_wdata = full row (new bit included); col=0, row++. After row ROWS-1 is written, write mode turns off.
  - '.'/'#' outside write mode, and any other byte: echo 'X'.
  - Any command other than a digit or '.'/'#' clears count and exits write mode; a partial row is discarded with no wr_en.
- Dump sequence:
  - Enter: disp_en=0; send CR (8'h0d), then LF (8'h0a).
  - Per row r = 0..ROWS-1: grid_row=r; DUMP_RD waits 1 cycle, then latches grid_rdata.
  - DUMP_CH sends COLS chars for bit 0..COLS-1: '#' if 1, '.' if 0.
  - DUMP_CR/DUMP_LF send CR, LF.
  - After the last row: disp_en=1, grid_row=0, state IDLE.
- Total dump bytes = 2 + ROWS*(COLS+2). Bytes are never duplicated or skipped under any tx_ready pattern.
- grid_wr_en and grid_step are never asserted in the same cycle.

Test Plan:
- Reset, then idle 20 cycles with tx_ready=1 -> all outputs at reset values; no strobes.
- ROWS=4, COLS=8; send "12s" -> echoes '1','2'; exactly 12 grid_step pulses, none adjacent; then echo 'S'; count back to 0 (a following 's' gives 1 pulse).
- Send 'w' then 32 chars, alternating '#','.' starting with '#' -> echo 'W' + 32 echoes; 4 wr_en pulses, rows 0..3, each grid_wdata=8'h55; write mode off (a 33rd '#' echoes 'X').
- Core model rows {8'h01,8'h80,8'hFF,8'h00}; send 'r' with tx_ready toggling 1-of-3 cycles -> exact 42-byte stream "\r\n#.......\r\n.......#\r\n########\r\n........\r\n"; disp_en=0 throughout; busy falls after the last LF.
- Send 's' while a dump is active -> rx_drop pulses once; the dump stream is unaltered; no step.
- Assert rst in the middle of DUMP_CH -> next cycle tx_valid=0, disp_en=1, state IDLE; a following 'S' works normally.
